// File: rtl/msrv32_decode_stage.sv
// msrv32_decode_stage: registered RV32I instruction-decode stage.
// Decodes instr_in into register addresses, a sign-extended immediate, class
// flags and the execute ALU opcode, held in one pipeline register behind a
// valid/ready handshake.
// Ports:
//   ms_riscv32_mp_clk_in / ms_riscv32_mp_rst_in : clock, sync active-high reset
//   instr_in, pc_in, instr_valid_in, instr_ready_out : fetch-side handshake
//   flush_in : drop held and incoming instruction
//   ex_ready_in, dec_valid_out : execute-side handshake
//   pc_out, rs1/rs2/rd_addr_out, imm_out, alu_opc_out, alu_src_imm_out,
//   funct3_out, class_out, wb_en_out, illegal_out : registered decode fields
module msrv32_decode_stage (
    input  logic        ms_riscv32_mp_clk_in,
    input  logic        ms_riscv32_mp_rst_in,
    input  logic [31:0] instr_in,
    input  logic [31:0] pc_in,
    input  logic        instr_valid_in,
    output logic        instr_ready_out,
    input  logic        flush_in,
    input  logic        ex_ready_in,
    output logic        dec_valid_out,
    output logic [31:0] pc_out,
    output logic [4:0]  rs1_addr_out,
    output logic [4:0]  rs2_addr_out,
    output logic [4:0]  rd_addr_out,
    output logic [31:0] imm_out,
    output logic [3:0]  alu_opc_out,
    output logic        alu_src_imm_out,
    output logic [2:0]  funct3_out,
    output logic [6:0]  class_out,
    output logic        wb_en_out,
    output logic        illegal_out
);

    localparam int unsigned XLEN    = 32;
    localparam int unsigned REG_AW  = 5;
    localparam int unsigned ALU_W   = 4;
    localparam int unsigned CLASS_W = 7;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [ALU_W-1:0] ALU_ADD  = 4'b0000;
    localparam logic [ALU_W-1:0] ALU_SUB  = 4'b1000;
    localparam logic [ALU_W-1:0] ALU_SLTU = 4'b0010;
    localparam logic [ALU_W-1:0] ALU_SLT  = 4'b0011;
    localparam logic [ALU_W-1:0] ALU_AND  = 4'b0111;
    localparam logic [ALU_W-1:0] ALU_OR   = 4'b0110;
    localparam logic [ALU_W-1:0] ALU_XOR  = 4'b0100;
    localparam logic [ALU_W-1:0] ALU_SRL  = 4'b0001;
    localparam logic [ALU_W-1:0] ALU_SLL  = 4'b0101;
    localparam logic [ALU_W-1:0] ALU_SRA  = 4'b1101;

    // one-hot {lui, auipc, jal, jalr, branch, load, store}
    localparam logic [CLASS_W-1:0] CLS_LUI    = 7'b1000000;
    localparam logic [CLASS_W-1:0] CLS_AUIPC  = 7'b0100000;
    localparam logic [CLASS_W-1:0] CLS_JAL    = 7'b0010000;
    localparam logic [CLASS_W-1:0] CLS_JALR   = 7'b0001000;
    localparam logic [CLASS_W-1:0] CLS_BRANCH = 7'b0000100;
    localparam logic [CLASS_W-1:0] CLS_LOAD   = 7'b0000010;
    localparam logic [CLASS_W-1:0] CLS_STORE  = 7'b0000001;

    typedef struct packed {
        logic [XLEN-1:0]    pc;
        logic [REG_AW-1:0]  rs1;
        logic [REG_AW-1:0]  rs2;
        logic [REG_AW-1:0]  rd;
        logic [XLEN-1:0]    imm;
        logic [ALU_W-1:0]   alu_opc;
        logic               alu_src_imm;
        logic [2:0]         funct3;
        logic [CLASS_W-1:0] cls;
        logic               wb_en;
        logic               illegal;
    } dec_t;

    // Arithmetic opcode for OP/OP-IMM; alt selects SUB/SRA.
    function automatic logic [ALU_W-1:0] arith_opc(input logic [2:0] f3, input logic alt);
        logic [ALU_W-1:0] opc;
        case (f3)
            3'b000:  opc = alt ? ALU_SUB : ALU_ADD;
            3'b001:  opc = ALU_SLL;
            3'b010:  opc = ALU_SLT;
            3'b011:  opc = ALU_SLTU;
            3'b100:  opc = ALU_XOR;
            3'b101:  opc = alt ? ALU_SRA : ALU_SRL;
            3'b110:  opc = ALU_OR;
            default: opc = ALU_AND;
        endcase
        return opc;
    endfunction

    logic [6:0]      opcode;
    logic [2:0]      f3;
    logic [6:0]      f7;
    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    assign opcode = instr_in[6:0];
    assign f3     = instr_in[14:12];
    assign f7     = instr_in[31:25];

    // Immediate formats, sign from instr[31]
    assign imm_i = {{20{instr_in[31]}}, instr_in[31:20]};
    assign imm_s = {{20{instr_in[31]}}, instr_in[31:25], instr_in[11:7]};
    assign imm_b = {{19{instr_in[31]}}, instr_in[31], instr_in[7], instr_in[30:25],
                    instr_in[11:8], 1'b0};
    assign imm_u = {instr_in[31:12], 12'b0};
    assign imm_j = {{11{instr_in[31]}}, instr_in[31], instr_in[19:12], instr_in[20],
                    instr_in[30:21], 1'b0};

    dec_t dec_d, dec_q;
    logic valid_d, valid_q;
    logic load_d;
    logic wb_cls;
    logic ill;
    logic capture;

    // Combinational decode of the incoming instruction
    always_comb begin
        dec_d        = '0;
        wb_cls       = 1'b0;
        ill          = 1'b0;
        dec_d.pc     = pc_in;
        dec_d.rs1    = instr_in[19:15];
        dec_d.rs2    = instr_in[24:20];
        dec_d.rd     = instr_in[11:7];
        dec_d.funct3 = f3;
        case (opcode)
            OPC_LUI: begin
                dec_d.cls = CLS_LUI;   dec_d.imm = imm_u; dec_d.alu_src_imm = 1'b1; wb_cls = 1'b1;
            end
            OPC_AUIPC: begin
                dec_d.cls = CLS_AUIPC; dec_d.imm = imm_u; dec_d.alu_src_imm = 1'b1; wb_cls = 1'b1;
            end
            OPC_JAL: begin
                dec_d.cls = CLS_JAL;   dec_d.imm = imm_j; wb_cls = 1'b1;
            end
            OPC_JALR: begin
                dec_d.cls = CLS_JALR;  dec_d.imm = imm_i; dec_d.alu_src_imm = 1'b1; wb_cls = 1'b1;
                ill = (f3 != 3'b000);
            end
            OPC_BRANCH: begin
                dec_d.cls = CLS_BRANCH; dec_d.imm = imm_b;
                ill = (f3[2:1] == 2'b01);
                case (f3[2:1])
                    2'b00:   dec_d.alu_opc = ALU_SUB;
                    2'b10:   dec_d.alu_opc = ALU_SLT;
                    default: dec_d.alu_opc = ALU_SLTU;
                endcase
            end
            OPC_LOAD: begin
                dec_d.cls = CLS_LOAD;  dec_d.imm = imm_i; dec_d.alu_src_imm = 1'b1; wb_cls = 1'b1;
                ill = (f3 == 3'b011) || (f3[2:1] == 2'b11);
            end
            OPC_STORE: begin
                dec_d.cls = CLS_STORE; dec_d.imm = imm_s; dec_d.alu_src_imm = 1'b1;
                ill = (f3 > 3'b010);
            end
            OPC_OPIMM: begin
                dec_d.imm = imm_i; dec_d.alu_src_imm = 1'b1; wb_cls = 1'b1;
                // only the shift-right immediate honours instr[30]; ADDI never becomes SUB
                dec_d.alu_opc = arith_opc(f3, (f3 == 3'b101) && instr_in[30]);
                if (f3 == 3'b001)
                    ill = (f7 != 7'b0000000);
                else if (f3 == 3'b101)
                    ill = (f7 != 7'b0000000) && (f7 != 7'b0100000);
            end
            OPC_OP: begin
                wb_cls = 1'b1;
                dec_d.alu_opc = arith_opc(f3, instr_in[30]);
                if (f7 == 7'b0100000)
                    ill = (f3 != 3'b000) && (f3 != 3'b101);
                else
                    ill = (f7 != 7'b0000000);
            end
            default: ill = 1'b1;
        endcase
        // illegal instructions flow as inert bubbles-with-flag
        if (ill) begin
            dec_d.cls         = '0;
            dec_d.alu_opc     = ALU_ADD;
            dec_d.alu_src_imm = 1'b0;
        end
        dec_d.illegal = ill;
        dec_d.wb_en   = wb_cls && !ill && (instr_in[11:7] != REG_AW'(0));
    end

    assign instr_ready_out = !valid_q || ex_ready_in;
    assign capture         = instr_valid_in && instr_ready_out;

    // Pipeline-register control: flush > capture > transfer > hold
    always_comb begin
        valid_d = valid_q;
        load_d  = 1'b0;
        if (flush_in) begin
            valid_d = 1'b0;
        end else if (capture) begin
            valid_d = 1'b1;
            load_d  = 1'b1;
        end else if (ex_ready_in) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge ms_riscv32_mp_clk_in) begin
        if (ms_riscv32_mp_rst_in) begin
            valid_q <= 1'b0;
            dec_q   <= '0;
        end else begin
            valid_q <= valid_d;
            if (load_d) dec_q <= dec_d;
        end
    end

    assign dec_valid_out   = valid_q;
    assign pc_out          = dec_q.pc;
    assign rs1_addr_out    = dec_q.rs1;
    assign rs2_addr_out    = dec_q.rs2;
    assign rd_addr_out     = dec_q.rd;
    assign imm_out         = dec_q.imm;
    assign alu_opc_out     = dec_q.alu_opc;
    assign alu_src_imm_out = dec_q.alu_src_imm;
    assign funct3_out      = dec_q.funct3;
    assign class_out       = dec_q.cls;
    assign wb_en_out       = dec_q.wb_en;
    assign illegal_out     = dec_q.illegal;

endmodule

// File: tb/tb_msrv32_decode_stage.sv
// tb_msrv32_decode_stage: directed plus randomized bench for the decode stage,
// checked every cycle against a mnemonic-level reference model.
module tb_msrv32_decode_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        ivalid;
    logic        iready;
    logic        flush;
    logic        ex_ready;
    logic        dvalid;
    logic [31:0] pc_o;
    logic [4:0]  rs1_o, rs2_o, rd_o;
    logic [31:0] imm_o;
    logic [3:0]  alu_o;
    logic        src_o;
    logic [2:0]  f3_o;
    logic [6:0]  cls_o;
    logic        wb_o;
    logic        ill_o;

    msrv32_decode_stage dut (
        .ms_riscv32_mp_clk_in (clk),
        .ms_riscv32_mp_rst_in (rst),
        .instr_in             (instr),
        .pc_in                (pc),
        .instr_valid_in       (ivalid),
        .instr_ready_out      (iready),
        .flush_in             (flush),
        .ex_ready_in          (ex_ready),
        .dec_valid_out        (dvalid),
        .pc_out               (pc_o),
        .rs1_addr_out         (rs1_o),
        .rs2_addr_out         (rs2_o),
        .rd_addr_out          (rd_o),
        .imm_out              (imm_o),
        .alu_opc_out          (alu_o),
        .alu_src_imm_out      (src_o),
        .funct3_out           (f3_o),
        .class_out            (cls_o),
        .wb_en_out            (wb_o),
        .illegal_out          (ill_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  rs1, rs2, rd;
        logic [31:0] imm;
        logic [3:0]  alu;
        logic        src;
        logic [2:0]  f3;
        logic [6:0]  cls;
        logic        wb;
        logic        ill;
    } exp_t;

    int   checks = 0;
    int   errors = 0;
    exp_t e;
    logic e_valid = 1'b0;
    logic e_zero  = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
        end
    endtask

    // ALU code from the instruction mnemonic
    function automatic logic [3:0] alu_of(input string mn);
        case (mn)
            "SUB", "BEQ", "BNE":                   return 4'b1000;
            "SLT", "SLTI", "BLT", "BGE":           return 4'b0011;
            "SLTU", "SLTIU", "BLTU", "BGEU":       return 4'b0010;
            "AND", "ANDI":                         return 4'b0111;
            "OR", "ORI":                           return 4'b0110;
            "XOR", "XORI":                         return 4'b0100;
            "SRL", "SRLI":                         return 4'b0001;
            "SLL", "SLLI":                         return 4'b0101;
            "SRA", "SRAI":                         return 4'b1101;
            default:                               return 4'b0000;
        endcase
    endfunction

    // Reference decode: name the instruction, then derive every field from it
    function automatic exp_t ref_decode(input logic [31:0] ins, input logic [31:0] p);
        exp_t r;
        string mn;
        int signed si;
        logic [2:0] fn3;
        logic [6:0] fn7;
        r = '0;
        r.pc  = p;
        r.rs1 = ins[19:15];
        r.rs2 = ins[24:20];
        r.rd  = ins[11:7];
        r.f3  = ins[14:12];
        fn3 = ins[14:12];
        fn7 = ins[31:25];
        si  = $signed(ins);
        mn  = "ILLEGAL";
        case (ins[6:0])
            7'b0110111: begin mn = "LUI";   r.imm = ins & 32'hFFFFF000; r.cls = 7'b1000000; r.src = 1'b1; end
            7'b0010111: begin mn = "AUIPC"; r.imm = ins & 32'hFFFFF000; r.cls = 7'b0100000; r.src = 1'b1; end
            7'b1101111: begin
                mn = "JAL"; r.cls = 7'b0010000;
                r.imm = 32'((si >>> 31) << 20) | (32'(ins[19:12]) << 12) | (32'(ins[20]) << 11)
                      | (32'(ins[30:21]) << 1);
            end
            7'b1100111: begin
                if (fn3 == 3'd0) mn = "JALR";
                r.imm = 32'(si >>> 20); r.cls = 7'b0001000; r.src = 1'b1;
            end
            7'b1100011: begin
                case (fn3)
                    3'd0: mn = "BEQ";  3'd1: mn = "BNE";  3'd4: mn = "BLT";
                    3'd5: mn = "BGE";  3'd6: mn = "BLTU"; 3'd7: mn = "BGEU";
                    default: mn = "ILLEGAL";
                endcase
                r.cls = 7'b0000100;
                r.imm = 32'((si >>> 31) << 12) | (32'(ins[7]) << 11) | (32'(ins[30:25]) << 5)
                      | (32'(ins[11:8]) << 1);
            end
            7'b0000011: begin
                case (fn3)
                    3'd0: mn = "LB"; 3'd1: mn = "LH"; 3'd2: mn = "LW";
                    3'd4: mn = "LBU"; 3'd5: mn = "LHU";
                    default: mn = "ILLEGAL";
                endcase
                r.imm = 32'(si >>> 20); r.cls = 7'b0000010; r.src = 1'b1;
            end
            7'b0100011: begin
                case (fn3)
                    3'd0: mn = "SB"; 3'd1: mn = "SH"; 3'd2: mn = "SW";
                    default: mn = "ILLEGAL";
                endcase
                r.imm = 32'((si >>> 25) << 5) | 32'(ins[11:7]); r.cls = 7'b0000001; r.src = 1'b1;
            end
            7'b0010011: begin
                r.imm = 32'(si >>> 20); r.src = 1'b1;
                case (fn3)
                    3'd0: mn = "ADDI"; 3'd2: mn = "SLTI"; 3'd3: mn = "SLTIU";
                    3'd4: mn = "XORI"; 3'd6: mn = "ORI";  3'd7: mn = "ANDI";
                    3'd1: mn = (fn7 == 7'h00) ? "SLLI" : "ILLEGAL";
                    default: mn = (fn7 == 7'h00) ? "SRLI" : (fn7 == 7'h20) ? "SRAI" : "ILLEGAL";
                endcase
            end
            7'b0110011: begin
                if (fn7 == 7'h00) begin
                    case (fn3)
                        3'd0: mn = "ADD"; 3'd1: mn = "SLL"; 3'd2: mn = "SLT"; 3'd3: mn = "SLTU";
                        3'd4: mn = "XOR"; 3'd5: mn = "SRL"; 3'd6: mn = "OR";  default: mn = "AND";
                    endcase
                end else if (fn7 == 7'h20) begin
                    if (fn3 == 3'd0) mn = "SUB";
                    else if (fn3 == 3'd5) mn = "SRA";
                end
            end
            default: mn = "ILLEGAL";
        endcase
        r.ill = (mn == "ILLEGAL");
        if (r.ill) r.cls = '0;
        r.alu = alu_of(mn);
        // branches and stores never write back
        r.wb  = !r.ill && !r.cls[2] && !r.cls[0] && (r.rd != 5'd0);
        return r;
    endfunction

    task automatic check_outputs();
        chk("dec_valid", 32'(dvalid), 32'(e_valid));
        if (e_valid || e_zero) begin
            chk("pc",      pc_o,          e.pc);
            chk("rs1",     32'(rs1_o),    32'(e.rs1));
            chk("rs2",     32'(rs2_o),    32'(e.rs2));
            chk("rd",      32'(rd_o),     32'(e.rd));
            chk("funct3",  32'(f3_o),     32'(e.f3));
            chk("class",   32'(cls_o),    32'(e.cls));
            chk("wb_en",   32'(wb_o),     32'(e.wb));
            chk("illegal", 32'(ill_o),    32'(e.ill));
            chk("alu_opc", 32'(alu_o),    32'(e.alu));
            if (!e.ill) begin
                chk("imm",     imm_o,       e.imm);
                chk("alu_src", 32'(src_o),  32'(e.src));
            end
        end
    endtask

    // One clock: drive inputs, check ready, advance the model, check outputs
    task automatic step(input logic r, input logic v, input logic fl, input logic exr,
                        input logic [31:0] ins, input logic [31:0] p);
        rst = r; ivalid = v; flush = fl; ex_ready = exr; instr = ins; pc = p;
        #1;
        if (!r) chk("instr_ready", 32'(iready), 32'(!e_valid || exr));
        @(posedge clk);
        if (r) begin
            e = '0; e_valid = 1'b0; e_zero = 1'b1;
        end else if (fl) begin
            e_valid = 1'b0;
        end else if (v && (!e_valid || exr)) begin
            e = ref_decode(ins, p); e_valid = 1'b1; e_zero = 1'b0;
        end else if (exr) begin
            e_valid = 1'b0;
        end
        #1;
        check_outputs();
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        logic [6:0]  ops [11];
        int k;
        int sel;
        ops = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011, 7'b0000011,
                7'b0100011, 7'b0010011, 7'b0110011, 7'b0110011, 7'b0001111};
        w = $urandom;
        k = $urandom_range(0, 11);
        if (k == 11) return w;
        w[6:0] = ops[k];
        if (k >= 7 && k <= 9) begin
            sel = $urandom_range(0, 3);
            if (sel < 2) w[31:25] = 7'h00;
            else if (sel == 2) w[31:25] = 7'h20;
        end
        if (k == 3 && $urandom_range(0, 1) == 1) w[14:12] = 3'd0;
        return w;
    endfunction

    initial begin
        rst = 1'b1; ivalid = 1'b0; flush = 1'b0; ex_ready = 1'b0; instr = '0; pc = '0;
        // reset state
        step(1, 0, 0, 0, 32'h0, 32'h0);
        step(1, 0, 0, 0, 32'h0, 32'h0);
        chk("rst_valid", 32'(dvalid), 32'd0);
        chk("rst_imm", imm_o, 32'd0);
        chk("rst_class", 32'(cls_o), 32'd0);
        chk("rst_illegal", 32'(ill_o), 32'd0);

        // ADDI x1,x2,-1
        step(0, 1, 0, 1, 32'hFFF10093, 32'h100);
        chk("addi_valid", 32'(dvalid), 32'd1);
        chk("addi_rd", 32'(rd_o), 32'd1);
        chk("addi_rs1", 32'(rs1_o), 32'd2);
        chk("addi_imm", imm_o, 32'hFFFFFFFF);
        chk("addi_alu", 32'(alu_o), 32'h0);
        chk("addi_src", 32'(src_o), 32'd1);
        chk("addi_wb", 32'(wb_o), 32'd1);

        // back-to-back SUB, SLL, SRAI
        step(0, 1, 0, 1, 32'h402081B3, 32'h104);
        chk("sub_alu", 32'(alu_o), 32'b1000);
        step(0, 1, 0, 1, 32'h002091B3, 32'h108);
        chk("sll_alu", 32'(alu_o), 32'b0101);
        step(0, 1, 0, 1, 32'h40335293, 32'h10C);
        chk("srai_alu", 32'(alu_o), 32'b1101);
        chk("srai_imm", imm_o, 32'h00000403);
        chk("srai_src", 32'(src_o), 32'd1);

        // stall three cycles behind a held ADD, then release into XOR
        step(0, 1, 0, 1, 32'h002081B3, 32'h200);
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 0, 0, 32'h0020C1B3, 32'h204);
            chk("stall_ready", 32'(iready), 32'd0);
            chk("stall_pc", pc_o, 32'h200);
            chk("stall_alu", 32'(alu_o), 32'h0);
        end
        step(0, 1, 0, 1, 32'h0020C1B3, 32'h204);
        chk("release_pc", pc_o, 32'h204);
        chk("release_alu", 32'(alu_o), 32'b0100);

        // illegal encodings
        step(0, 1, 0, 1, 32'h00000000, 32'h300);
        chk("zero_illegal", 32'(ill_o), 32'd1);
        chk("zero_wb", 32'(wb_o), 32'd0);
        chk("zero_class", 32'(cls_o), 32'd0);
        chk("zero_valid", 32'(dvalid), 32'd1);
        step(0, 1, 0, 1, 32'h022081B3, 32'h304);
        chk("mul_illegal", 32'(ill_o), 32'd1);
        chk("mul_wb", 32'(wb_o), 32'd0);
        chk("mul_valid", 32'(dvalid), 32'd1);

        // flush while held and stalled, with a valid incoming instruction
        step(0, 1, 0, 1, 32'hFFF10093, 32'h400);
        step(0, 1, 1, 0, 32'h402081B3, 32'h404);
        chk("flush_valid", 32'(dvalid), 32'd0);
        step(0, 0, 0, 0, 32'h0, 32'h0);
        chk("flush_nocap", 32'(dvalid), 32'd0);

        // synchronous reset during a stall
        step(0, 1, 0, 1, 32'hFFF10093, 32'h500);
        step(0, 0, 0, 0, 32'h0, 32'h0);
        step(1, 1, 0, 0, 32'h402081B3, 32'h504);
        chk("rstst_valid", 32'(dvalid), 32'd0);
        chk("rstst_pc", pc_o, 32'd0);
        chk("rstst_imm", imm_o, 32'd0);
        chk("rstst_wb", 32'(wb_o), 32'd0);
        step(0, 1, 0, 0, 32'h402081B3, 32'h508);
        chk("rstst_resume", 32'(dvalid), 32'd1);
        chk("rstst_alu", 32'(alu_o), 32'b1000);

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            step(($urandom_range(0, 99) == 0),
                 ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 15) == 0),
                 ($urandom_range(0, 2) != 0),
                 rand_instr(), $urandom & 32'hFFFFFFFC);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/msrv32_decode_stage.md
# msrv32_decode_stage

Registered instruction-decode stage for the RV32I core. It sits between fetch and execute and turns a raw 32-bit instruction into register addresses, a sign-extended immediate, instruction-class flags and the 4-bit ALU operation code the execute-stage ALU consumes. The outputs are held in a single pipeline register with a valid/ready handshake, so the stage absorbs execute stalls and fetch flushes without losing or duplicating instructions.

## Interface
- No parameters.
- ms_riscv32_mp_clk_in  in  1  clock; all state updates on its rising edge.
- ms_riscv32_mp_rst_in  in  1  reset, synchronous and active-high.
- instr_in  in  32  instruction word from fetch.
- pc_in  in  32  PC of instr_in.
- instr_valid_in  in  1  instr_in/pc_in valid this cycle.
- instr_ready_out  out  1  stage can accept instr_in this cycle.
- flush_in  in  1  discard held and incoming instruction (branch redirect).
- ex_ready_in  in  1  execute accepts the decoded instruction this cycle.
- dec_valid_out  out  1  decoded outputs valid.
- pc_out  out  32  registered PC.
- rs1_addr_out, rs2_addr_out, rd_addr_out  out  5 each  register addresses (instr[19:15], [24:20], [11:7]).
- imm_out  out  32  sign-extended immediate.
- alu_opc_out  out  4  ALU operation code.
- alu_src_imm_out  out  1  1 selects imm_out as ALU operand 2, 0 selects rs2.
- funct3_out  out  3  instr[14:12], for load/store width and branch condition.
- class_out  out  7  one-hot {lui, auipc, jal, jalr, branch, load, store}; all-zero for OP/OP-IMM.
- wb_en_out  out  1  register write-back required.
- illegal_out  out  1  instruction illegal.

## Operation
- Handshake: instr_ready_out = !dec_valid_out || ex_ready_in (combinational). Capture happens when instr_valid_in && instr_ready_out.
- Register update priority: reset > flush > capture > hold.
  - Reset: every registered output is 0, including dec_valid_out, illegal_out and class_out.
  - Flush: dec_valid_out is 0 next cycle, and any same-cycle input is dropped.
  - Capture: all fields load from the decode of instr_in, and dec_valid_out is 1.
  - Transfer without capture (ex_ready_in && dec_valid_out && no capture): dec_valid_out is 0.
  - Otherwise all outputs hold, bit-stable, while dec_valid_out && !ex_ready_in.
- Immediate by format, with instr[31] as the sign bit:
  - I: instr[31:20].
  - S: {instr[31:25], instr[11:7]}.
  - B: {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  - U: {instr[31:12], 12'b0}.
  - J: {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
  - R-type: 0.
- ALU code, fixed mapping matching the execute ALU:
  - ADD 0000, SUB 1000, SLTU 0010, SLT 0011.
  - AND 0111, OR 0110, XOR 0100.
  - SRL 0001, SLL 0101, SRA 1101.
  - Note that SLL/SRL and SLT/SLTU do not equal funct3 or {funct7[5], funct3}; decode explicitly.
- Code per instruction class:
  - OP / OP-IMM: per funct3/funct7. OP-IMM never yields SUB.
  - Load, store, jalr, auipc, lui, jal: ADD.
  - BEQ/BNE: SUB. BLT/BGE: SLT. BLTU/BGEU: SLTU.
- alu_src_imm_out is 1 for OP-IMM, load, store, jalr, lui and auipc; 0 otherwise.
- wb_en_out is 1 for OP, OP-IMM, load, lui, auipc, jal and jalr, and only when rd != 0 and the instruction is legal.
- illegal_out is 1 for any of the following:
  - instr[1:0] != 11.
  - An opcode outside the nine RV32I classes above (FENCE/SYSTEM are treated as illegal by this stage).
  - OP with funct7 not 0000000/0100000, or funct7 = 0100000 with funct3 not 000/101.
  - SLLI with funct7 != 0.
  - SRLI/SRAI with funct7 not 0000000/0100000.
  - Branch with funct3 010/011.
  - Load with funct3 011/110/111.
  - Store with funct3 > 010.
  - JALR with funct3 != 0.
- An illegal instruction still flows with dec_valid_out = 1, class_out = 0, wb_en_out = 0 and alu_opc_out = 0000.

## Timing
- Latency is 1 cycle from capture to dec_valid_out.
- Throughput is 1 instruction/cycle while ex_ready_in = 1.
- instr_ready_out has a combinational path from ex_ready_in only. No combinational path exists from instr_in to any output.
- Capture in the same cycle as a transfer is permitted; dec_valid_out stays 1 with the new contents.
- Reset asserted mid-stall drops the held instruction; the first capture can occur in the cycle after reset deasserts.
- Flush asserted with ex_ready_in = 0 still clears dec_valid_out next cycle.

## Test plan
- Reset, then ADDI x1,x2,-1 (0xFFF10093) with ex_ready_in = 1 -> next cycle:
  - dec_valid_out = 1, rd = 1, rs1 = 2, imm_out = 0xFFFFFFFF.
  - alu_opc_out = 0000, alu_src_imm_out = 1, wb_en_out = 1.
- Back-to-back SUB x3,x1,x2 (0x402081B3), SLL x3,x1,x2 (0x002091B3), SRAI x5,x6,3 (0x40335293) -> on consecutive cycles:
  - alu_opc_out = 1000, 0101, 1101.
  - SRAI: imm_out = 0x00000403, alu_src_imm_out = 1.
- Stall: hold ex_ready_in = 0 for 3 cycles after a capture -> instr_ready_out = 0, and all outputs are bit-identical across the stall. On release, the next instruction appears with no drop or duplicate.
- instr_in = 0x00000000, and separately funct7 = 0000001 on OP (0x022081B3) -> illegal_out = 1, wb_en_out = 0, class_out = 0, dec_valid_out = 1.
- Flush with instr_valid_in = 1 and ex_ready_in = 0 while an instruction is held -> dec_valid_out = 0 next cycle; the incoming instruction is not captured.
- Synchronous reset asserted during a stall -> all outputs are 0 next cycle; capture resumes the first cycle after deassertion.
